// File: rtl/phys_reg_freelist_if.sv
// Rename/commit handshake bundle for the integer physical-register free list.
// slave = free list side, master = rename/ROB side.
interface phys_reg_freelist_if #(
    parameter int unsigned PHYREG_NUM   = 64,
    parameter int unsigned ARCHREG_NUM  = 32,
    parameter int unsigned ALLOC_WIDTH  = 4,
    parameter int unsigned COMMIT_WIDTH = 4
);
    localparam int unsigned PW = $clog2(PHYREG_NUM);
    localparam int unsigned CW = $clog2(PHYREG_NUM - ARCHREG_NUM) + 1;

    logic                             o_can_alloc;
    logic                             i_alloc_vld;
    logic [ALLOC_WIDTH-1:0]           i_alloc_req;
    logic [ALLOC_WIDTH-1:0][PW-1:0]   o_alloc_prd;
    logic [COMMIT_WIDTH-1:0]          i_commit_vld;
    logic [COMMIT_WIDTH-1:0]          i_commit_has_rd;
    logic [COMMIT_WIDTH-1:0]          i_commit_ismv;
    logic [COMMIT_WIDTH-1:0][PW-1:0]  i_commit_prev_prd;
    logic                             i_squash_vld;
    logic [CW-1:0]                    o_free_count;
    logic                             o_error;

    modport slave (
        output o_can_alloc, o_alloc_prd, o_free_count, o_error,
        input  i_alloc_vld, i_alloc_req, i_commit_vld, i_commit_has_rd, i_commit_ismv,
               i_commit_prev_prd, i_squash_vld
    );

    modport master (
        input  o_can_alloc, o_alloc_prd, o_free_count, o_error,
        output i_alloc_vld, i_alloc_req, i_commit_vld, i_commit_has_rd, i_commit_ismv,
               i_commit_prev_prd, i_squash_vld
    );
endinterface

// File: rtl/phys_reg_freelist.sv
// Integer physical-register free list: circular buffer with speculative/architectural heads.
// Define FREELIST_CHECK_EN to add the is_free shadow vector and double-free/alloc checks.
module phys_reg_freelist #(
    parameter int unsigned PHYREG_NUM   = 64,
    parameter int unsigned ARCHREG_NUM  = 32,
    parameter int unsigned ALLOC_WIDTH  = 4,
    parameter int unsigned COMMIT_WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    phys_reg_freelist_if.slave fl
);
    localparam int unsigned DEPTH = PHYREG_NUM - ARCHREG_NUM;
    localparam int unsigned PW    = $clog2(PHYREG_NUM);
    localparam int unsigned IW    = $clog2(DEPTH);
    localparam int unsigned CW    = IW + 1;

    // Pointers carry a flip bit above the index; with DEPTH a power of two the
    // natural CW-bit wrap gives the flip toggle for free.
    logic [DEPTH-1:0][PW-1:0]        buf_q, buf_d;
    logic [CW-1:0]                   spec_head_q, spec_head_d;
    logic [CW-1:0]                   arch_head_q, arch_head_d;
    logic [CW-1:0]                   tail_q, tail_d;
    logic                            error_q, error_d;

    logic [CW-1:0]                   free_count;
    logic                            can_alloc;
    logic                            fire;
    logic [ALLOC_WIDTH-1:0][PW-1:0]  alloc_prd;
    logic [CW-1:0]                   n_alloc, alloc_pop;
    logic [COMMIT_WIDTH-1:0]         freeing;
    logic [CW-1:0]                   n_free;
    logic                            overflow, restore_err, chk_err;

    always_comb begin
        free_count = tail_q - spec_head_q;
        can_alloc  = free_count >= CW'(ALLOC_WIDTH);
        fire       = fl.i_alloc_vld & can_alloc & ~fl.i_squash_vld;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_prd[i] = buf_q[spec_head_q[IW-1:0] + IW'(i)];
        end
        n_alloc = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            n_alloc = n_alloc + CW'(fl.i_alloc_req[i]);
        end
        alloc_pop = fire ? n_alloc : '0;
    end

    always_comb begin
        freeing = fl.i_commit_vld & fl.i_commit_has_rd & ~fl.i_commit_ismv;
        buf_d   = buf_q;
        n_free  = '0;
        // Freeing lanes pack contiguously at the tail regardless of gaps between lanes.
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (freeing[i]) begin
                buf_d[tail_q[IW-1:0] + n_free[IW-1:0]] = fl.i_commit_prev_prd[i];
                n_free = n_free + 1'b1;
            end
        end
        tail_d      = tail_q + n_free;
        arch_head_d = arch_head_q + n_free;
        if (fl.i_squash_vld) begin
            spec_head_d = arch_head_d;
        end else begin
            spec_head_d = spec_head_q + alloc_pop;
        end
        overflow = ({1'b0, free_count} + {1'b0, n_free}) >
                   ((CW + 1)'(DEPTH) + {1'b0, alloc_pop});
        restore_err = fl.i_squash_vld && ((arch_head_d - arch_head_q) > (tail_d - arch_head_q));
        error_d = error_q | overflow | restore_err | chk_err;
    end

`ifdef FREELIST_CHECK_EN
    localparam logic [PHYREG_NUM-1:0] FreeInit = {{DEPTH{1'b1}}, {ARCHREG_NUM{1'b0}}};

    logic [PHYREG_NUM-1:0] is_free_q, is_free_d;
    logic [IW-1:0]         rb_off;
    logic [CW-1:0]         rb_cnt;

    always_comb begin
        is_free_d = is_free_q;
        chk_err   = 1'b0;
        rb_off    = '0;
        rb_cnt    = tail_d - arch_head_d;
        if (fire) begin
            for (int i = 0; i < ALLOC_WIDTH; i++) begin
                if (fl.i_alloc_req[i]) begin
                    if (!is_free_d[alloc_prd[i]]) chk_err = 1'b1;
                    is_free_d[alloc_prd[i]] = 1'b0;
                end
            end
        end
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (freeing[i]) begin
                if (fl.i_commit_prev_prd[i] == '0)         chk_err = 1'b1;
                if (is_free_d[fl.i_commit_prev_prd[i]])    chk_err = 1'b1;
                is_free_d[fl.i_commit_prev_prd[i]] = 1'b1;
            end
        end
        // Squash: only entries from the restored head up to the new tail are free.
        if (fl.i_squash_vld) begin
            is_free_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                rb_off = IW'(k) - arch_head_d[IW-1:0];
                if ({1'b0, rb_off} < rb_cnt) is_free_d[buf_d[k]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_free_q <= FreeInit;
        end else begin
            is_free_q <= is_free_d;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                buf_q[k] <= PW'(ARCHREG_NUM + k);
            end
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q      <= {1'b1, {IW{1'b0}}};
            error_q     <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q      <= tail_d;
            error_q     <= error_d;
        end
    end

    assign fl.o_can_alloc  = can_alloc;
    assign fl.o_alloc_prd  = alloc_prd;
    assign fl.o_free_count = free_count;
    assign fl.o_error      = error_q;
endmodule

// File: tb/tb_phys_reg_freelist.sv
// Directed scoreboard bench for phys_reg_freelist (default parameters, DEPTH = 32).
module tb_phys_reg_freelist;
    localparam int unsigned PW = 6;

    logic clk;
    logic rst;

    phys_reg_freelist_if #(
        .PHYREG_NUM  (64),
        .ARCHREG_NUM (32),
        .ALLOC_WIDTH (4),
        .COMMIT_WIDTH(4)
    ) fl_if ();

    phys_reg_freelist #(
        .PHYREG_NUM  (64),
        .ARCHREG_NUM (32),
        .ALLOC_WIDTH (4),
        .COMMIT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fl (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {KCount, KCan, KErr, KPrd} kind_e;
    typedef struct {
        string tag;
        kind_e kind;
        int    lane;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    task automatic expect_val(input string tag, input kind_e kind, input int lane, input int exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.lane = lane;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_e kind, input int lane);
        case (kind)
            KCount:  return 32'(fl_if.o_free_count);
            KCan:    return 32'(fl_if.o_can_alloc);
            KErr:    return 32'(fl_if.o_error);
            default: return 32'(fl_if.o_alloc_prd[lane]);
        endcase
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind, e.lane);
            checks++;
            assert (obs === 32'(e.exp)) else begin
                errors++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic idle();
        fl_if.i_alloc_vld       = 1'b0;
        fl_if.i_alloc_req       = '0;
        fl_if.i_commit_vld      = '0;
        fl_if.i_commit_has_rd   = '0;
        fl_if.i_commit_ismv     = '0;
        fl_if.i_commit_prev_prd = '0;
        fl_if.i_squash_vld      = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] req);
        fl_if.i_alloc_vld = 1'b1;
        fl_if.i_alloc_req = req;
    endtask

    task automatic commit(input logic [3:0] vld, input logic [3:0] has_rd, input logic [3:0] ismv,
                          input int p0, input int p1, input int p2, input int p3);
        fl_if.i_commit_vld         = vld;
        fl_if.i_commit_has_rd      = has_rd;
        fl_if.i_commit_ismv        = ismv;
        fl_if.i_commit_prev_prd[0] = PW'(p0);
        fl_if.i_commit_prev_prd[1] = PW'(p1);
        fl_if.i_commit_prev_prd[2] = PW'(p2);
        fl_if.i_commit_prev_prd[3] = PW'(p3);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle();
        repeat (2) cycle();

        // Reset state
        expect_val("rst_count", KCount, 0, 32);
        expect_val("rst_can", KCan, 0, 1);
        expect_val("rst_err", KErr, 0, 0);
        for (int i = 0; i < 4; i++) expect_val("rst_prd", KPrd, i, 32 + i);
        check_all();
        rst = 1'b1;
        cycle();

        // Partial allocation of three lanes
        alloc(4'b0111);
        #1;
        for (int i = 0; i < 3; i++) expect_val("a3_prd", KPrd, i, 32 + i);
        check_all();
        cycle();
        idle();
        expect_val("a3_count", KCount, 0, 29);
        expect_val("a3_prd0", KPrd, 0, 35);
        check_all();

        // Asynchronous reset in the middle of a firing allocation
        alloc(4'b1111);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_val("arst_count", KCount, 0, 32);
        expect_val("arst_prd0", KPrd, 0, 32);
        check_all();
        idle();
        cycle();
        rst = 1'b1;
        cycle();

        // Drain the list four at a time
        for (int c = 1; c <= 8; c++) begin
            alloc(4'b1111);
            cycle();
            expect_val("drain_count", KCount, 0, 32 - 4 * c);
            expect_val("drain_can", KCan, 0, (32 - 4 * c) >= 4 ? 1 : 0);
            check_all();
        end
        // Requests while empty are ignored
        repeat (2) cycle();
        idle();
        expect_val("empty_count", KCount, 0, 0);
        expect_val("empty_can", KCan, 0, 0);
        expect_val("empty_prd0", KPrd, 0, 32);
        check_all();

        // Refill across the wrap point
        commit(4'b1111, 4'b1111, 4'b0000, 5, 6, 7, 8);
        cycle();
        idle();
        expect_val("wrap_count", KCount, 0, 4);
        expect_val("wrap_can", KCan, 0, 1);
        for (int i = 0; i < 4; i++) expect_val("wrap_prd", KPrd, i, 5 + i);
        expect_val("wrap_err", KErr, 0, 0);
        check_all();

        // Non-freeing commit lanes
        commit(4'b1111, 4'b0101, 4'b0101, 9, 10, 11, 12);
        cycle();
        idle();
        expect_val("nofree_count", KCount, 0, 4);
        expect_val("nofree_prd0", KPrd, 0, 5);
        check_all();
        // Squash alone exposes arch_head: it must still be 4
        fl_if.i_squash_vld = 1'b1;
        cycle();
        idle();
        expect_val("nofree_sq_count", KCount, 0, 32);
        expect_val("nofree_sq_prd0", KPrd, 0, 36);
        expect_val("nofree_sq_err", KErr, 0, 0);
        check_all();

        // Squash with same-cycle commits
        do_reset();
        alloc(4'b1111);
        #1;
        expect_val("sq_a0_prd0", KPrd, 0, 32);
        check_all();
        cycle();
        expect_val("sq_a1_prd0", KPrd, 0, 36);
        check_all();
        cycle();
        idle();
        expect_val("sq_pre_count", KCount, 0, 24);
        check_all();
        alloc(4'b1111);
        commit(4'b0011, 4'b0011, 4'b0000, 1, 2, 0, 0);
        fl_if.i_squash_vld = 1'b1;
        cycle();
        idle();
        expect_val("sq_count", KCount, 0, 32);
        expect_val("sq_prd0", KPrd, 0, 34);
        expect_val("sq_prd1", KPrd, 1, 35);
        expect_val("sq_can", KCan, 0, 1);
        expect_val("sq_err", KErr, 0, 0);
        check_all();
        alloc(4'b0001);
        cycle();
        idle();
        expect_val("post_sq_count", KCount, 0, 31);
        expect_val("post_sq_prd0", KPrd, 0, 35);
        check_all();

        // Overflow: two frees onto 31 free entries
        commit(4'b0011, 4'b0011, 4'b0000, 40, 41, 0, 0);
        cycle();
        idle();
        expect_val("ovf_err", KErr, 0, 1);
        check_all();
        repeat (3) cycle();
        expect_val("ovf_sticky", KErr, 0, 1);
        check_all();
        // Still operating after the error
        alloc(4'b1111);
        cycle();
        idle();
        expect_val("ovf_live_count", KCount, 0, 29);
        expect_val("ovf_live_err", KErr, 0, 1);
        check_all();
        rst = 1'b0;
        #1;
        expect_val("ovf_rst_err", KErr, 0, 0);
        check_all();
        cycle();
        rst = 1'b1;
        cycle();

`ifdef FREELIST_CHECK_EN
        // Double free of a preg that is still free, without overflow
        alloc(4'b1111);
        cycle();
        idle();
        expect_val("dbl_pre_err", KErr, 0, 0);
        check_all();
        commit(4'b0001, 4'b0001, 4'b0000, 40, 0, 0, 0);
        cycle();
        idle();
        expect_val("dbl_err", KErr, 0, 1);
        expect_val("dbl_count", KCount, 0, 29);
        check_all();
        repeat (2) cycle();
        expect_val("dbl_sticky", KErr, 0, 1);
        check_all();
        do_reset();
        expect_val("dbl_rst_err", KErr, 0, 0);
        check_all();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/phys_reg_freelist.md
Name: phys_reg_freelist

Overview:
- Integer physical-register free list, feeding rename and fed back by commit.
- Rename stage pops up to ALLOC_WIDTH free pregs per cycle for new destinations.
- ROB commit stage pushes back the `prev_iprd_idx` of each committed writer.
- A squash from the ROB rewinds the speculative head to the architectural (committed) head.

Parameters:
- PHYREG_NUM, 64, number of integer physical registers.
- ARCHREG_NUM, 32, architectural registers. At reset, arch reg r maps to preg r.
- ALLOC_WIDTH, 4, rename lanes (equals RENAME_WIDTH).
- COMMIT_WIDTH, 4, commit lanes (equals COMMIT_WIDTH).
- Derived: DEPTH = PHYREG_NUM-ARCHREG_NUM (must be a power of two); PW = $clog2(PHYREG_NUM); CW = $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- o_can_alloc  out  1  at least ALLOC_WIDTH pregs are speculatively free.
- i_alloc_vld  in  1  rename fires this cycle.
- i_alloc_req  in  ALLOC_WIDTH  per-lane request; ordered (contiguous from lane 0).
- o_alloc_prd  out  ALLOC_WIDTH x PW  candidate preg per lane.
- i_commit_vld  in  COMMIT_WIDTH  ROB commit lanes; ordered.
- i_commit_has_rd  in  COMMIT_WIDTH  committed inst writes a register.
- i_commit_ismv  in  COMMIT_WIDTH  eliminated move.
- i_commit_prev_prd  in  COMMIT_WIDTH x PW  previous mapping of rd, to be freed.
- i_squash_vld  in  1  ROB squash (branch mispredict or trap).
- o_free_count  out  CW  speculative free entries.
- o_error  out  1  sticky error flag.

Behaviour:
Storage and pointers:
- Circular buffer of DEPTH entries, each PW bits.
- Three pointers, each with a flip bit: `spec_head` (rename pop), `arch_head` (committed pop), `tail` (push).
- Reset contents: entry k = ARCHREG_NUM+k. Pointers: spec_head = arch_head = 0; tail = {flip 1, idx 0} (full).
- Reset outputs: o_can_alloc=1, o_free_count=DEPTH, o_error=0, o_alloc_prd[i]=ARCHREG_NUM+i.

Allocation:
- o_alloc_prd[i] = buf[(spec_head+i) mod DEPTH]. Combinational, valid whenever o_can_alloc=1.
- o_can_alloc = (o_free_count >= ALLOC_WIDTH). It is deliberately independent of i_alloc_req, to avoid a timing loop.
- Fire = i_alloc_vld & o_can_alloc & !i_squash_vld. On fire, spec_head += popcount(i_alloc_req) at the next edge.
- i_alloc_vld with o_can_alloc=0 is ignored.

Commit:
- Lane i is a freeing lane when i_commit_vld[i] & i_commit_has_rd[i] & !i_commit_ismv[i].
- Each freeing lane writes i_commit_prev_prd[i] at tail + (number of freeing lanes below i).
- Each freeing lane advances tail by 1 and arch_head by 1. The preg it consumed at rename is now architectural.
- ismv lanes neither allocate nor free; reference counting for eliminated moves is owned by rename.
- Commits take effect at the next edge. There is no bypass: freed pregs become visible to allocation one cycle later.

Squash:
- spec_head <= arch_head_next, where arch_head_next includes same-cycle commits.
- Allocation is suppressed in the squash cycle. Commits in that cycle are still applied.

Counts and wrap-around:
- o_free_count = tail - spec_head, using flip-bit arithmetic: equal idx with differing flip means DEPTH; equal idx with equal flip means 0.
- Pointer idx wraps at DEPTH and toggles its flip bit.

Errors:
- o_error sets and holds when a push would make the count exceed DEPTH.
- o_error also sets and holds when the squash restore point is not between arch_head and tail.
- It is cleared only by reset.
- The block must keep operating after o_error is set; no state is frozen.

Reset mid-operation:
- An asynchronous reset returns all pointers and contents to the reset values immediately, regardless of in-flight alloc or commit.

Optional Feature:
- Macro: FREELIST_CHECK_EN.
- When defined:
  - Keep a PHYREG_NUM-bit `is_free` vector. Reset value: bits ARCHREG_NUM..PHYREG_NUM-1 set.
  - Allocation clears the bits of the allocated pregs; commit frees set the bits of the freed pregs.
  - Freeing a preg whose bit is already set sets o_error (double free).
  - Allocating a preg whose bit is clear sets o_error.
  - Freeing preg 0 sets o_error.
  - On squash, the vector is rebuilt from the entries between arch_head_next and tail.
- When undefined: none of this logic exists, and o_error reflects only the overflow and restore checks.

Test Plan:
- Reset, then one cycle alloc with req=4'b0111 → o_alloc_prd = 32,33,34 on lanes 0–2; next cycle o_free_count=29 and lane 0 shows 35.
- Allocate 4 per cycle for 8 cycles with no commits → o_free_count reaches 0, o_can_alloc drops in the cycle count<4 and stays 0, further i_alloc_vld is ignored with spec_head unchanged.
- From count 0: commit 4 lanes freeing 5, 6, 7, 8 (has_rd=1, ismv=0) → next cycle o_free_count=4, o_can_alloc=1, o_alloc_prd = 5,6,7,8 (wrap-around with flip toggle).
- Allocate 8 pregs (32–39), commit lanes for 2 of them (freeing 1, 2), assert squash in the same cycle → spec_head = arch_head+2, o_free_count = 32-2+2 = 32, next allocation returns 34.
- Commit lanes with ismv=1 or has_rd=0 → tail and arch_head unchanged, o_free_count unchanged.
- With FREELIST_CHECK_EN defined: commit-free preg 40 while it is already free → o_error=1 next cycle and stays 1 until rst is asserted low.
